// File: rtl/mult_accumulator.sv
// mult_accumulator: sums ACC_COUNT consecutive multiplier products.
// Products arrive on a valid/ready port. The completed sum is held on a
// second valid/ready port until that port accepts it.
// Optional macro MACC_SATURATE_EN: when it is defined, sums clamp to all-ones
// instead of wrapping.
module mult_accumulator #(
  parameter int INPUT1_WIDTH = 4,
  parameter int INPUT2_WIDTH = 5,
  parameter int ACC_WIDTH    = 16,
  parameter int ACC_COUNT    = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] z,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [ACC_WIDTH-1:0]                 acc_out,
  output logic                                 overflow
);

  localparam int PW = INPUT1_WIDTH + INPUT2_WIDTH;
  localparam int CW = (ACC_COUNT > 1) ? $clog2(ACC_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(ACC_COUNT - 1);

  // Reject parameter sets the datapath cannot represent.
  if (ACC_WIDTH < PW) begin : g_bad_width
    $error("mult_accumulator: ACC_WIDTH must be >= INPUT1_WIDTH+INPUT2_WIDTH");
  end
  if (ACC_COUNT < 1) begin : g_bad_count
    $error("mult_accumulator: ACC_COUNT must be >= 1");
  end

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t               state_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic [CW-1:0]        cnt_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] acc_out_q;
  logic                 out_valid_q;
  logic                 overflow_q;
  logic                 in_ready_q;

  logic [ACC_WIDTH:0]   sum;
  logic                 sum_c;
  logic [ACC_WIDTH-1:0] acc_d;
  logic                 accept;
  logic                 last;

  // One extra bit on the adder exposes the carry that marks an overflow.
  always_comb begin
    sum    = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - PW){1'b0}}, z};
    sum_c  = sum[ACC_WIDTH];
`ifdef MACC_SATURATE_EN
    acc_d  = sum_c ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    acc_d  = sum[ACC_WIDTH-1:0];
`endif
    accept = in_valid && in_ready_q;
    last   = (cnt_q == LAST);
  end

  // Control FSM and datapath. in_ready is registered, so it stays low for
  // the first cycle after reset and never depends on out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (state_q == ACCUM) begin
      in_ready_q <= 1'b1;
      if (accept) begin
        if (last) begin
          acc_out_q   <= acc_d;
          out_valid_q <= 1'b1;
          overflow_q  <= overflow_q | ovf_q | sum_c;
          ovf_q       <= 1'b0;
          acc_q       <= '0;
          cnt_q       <= '0;
          state_q     <= HOLD;
          in_ready_q  <= 1'b0;
        end else begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          ovf_q <= ovf_q | sum_c;
        end
      end
    end else begin
      if (out_ready) begin
        out_valid_q <= 1'b0;
        state_q     <= ACCUM;
        in_ready_q  <= 1'b1;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_mult_accumulator.sv
// Bench for mult_accumulator: three instances (default, ACC_WIDTH=11,
// ACC_COUNT=1) checked every cycle against a run-level behavioural model,
// plus directed literal expectations.
module tb_mult_accumulator;

`ifdef MACC_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // group A stimulus drives d0 and d1; d2 has its own
  logic       clr = 1'b0, iv = 1'b0, ordy = 1'b1;
  logic [8:0] zz = '0;
  logic       clr2 = 1'b0, iv2 = 1'b0, ordy2 = 1'b1;
  logic [8:0] z2 = '0;

  logic        rdy0, ov0, of0, rdy1, ov1, of1, rdy2, ov2, of2;
  logic [15:0] acc0, acc2;
  logic [10:0] acc1;

  mult_accumulator #(.ACC_WIDTH(16), .ACC_COUNT(8)) d0 (
    .clk(clk), .rst_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy0), .z(zz),
    .out_valid(ov0), .out_ready(ordy), .acc_out(acc0), .overflow(of0));
  mult_accumulator #(.ACC_WIDTH(11), .ACC_COUNT(8)) d1 (
    .clk(clk), .rst_n(rst_n), .clear(clr), .in_valid(iv), .in_ready(rdy1), .z(zz),
    .out_valid(ov1), .out_ready(ordy), .acc_out(acc1), .overflow(of1));
  mult_accumulator #(.ACC_WIDTH(16), .ACC_COUNT(1)) d2 (
    .clk(clk), .rst_n(rst_n), .clear(clr2), .in_valid(iv2), .in_ready(rdy2), .z(z2),
    .out_valid(ov2), .out_ready(ordy2), .acc_out(acc2), .overflow(of2));

  int nchk = 0;
  int nerr = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the exact run total decides result and overflow.
  typedef struct {
    bit     hold;
    bit     rdy;
    bit     ov;
    longint sum;
    int     cnt;
    longint res;
  } ms_t;

  ms_t m0, m1, m2;

  function automatic void mreset(inout ms_t s);
    s.hold = 0; s.rdy = 0; s.ov = 0; s.sum = 0; s.cnt = 0; s.res = 0;
  endfunction

  function automatic void step(input int w, input int n, input bit clr_i, input bit iv_i,
                               input bit ordy_i, input longint z_i, inout ms_t s);
    longint lim;
    bit     acc;
    lim = longint'(1) << w;
    if (clr_i) begin
      s.hold = 0; s.rdy = 1; s.ov = 0; s.sum = 0; s.cnt = 0;
    end else if (s.hold) begin
      if (ordy_i) begin
        s.hold = 0; s.rdy = 1;
      end
    end else begin
      acc = iv_i && s.rdy;
      s.rdy = 1;
      if (acc) begin
        s.sum += z_i;
        s.cnt++;
        if (s.cnt == n) begin
          if (s.sum >= lim) begin
            s.ov  = 1;
            s.res = SAT ? lim - 1 : s.sum % lim;
          end else begin
            s.res = s.sum;
          end
          s.hold = 1; s.rdy = 0; s.sum = 0; s.cnt = 0;
        end
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreset(m0); mreset(m1); mreset(m2);
    end else begin
      step(16, 8, clr, iv, ordy, longint'(zz), m0);
      step(11, 8, clr, iv, ordy, longint'(zz), m1);
      step(16, 1, clr2, iv2, ordy2, longint'(z2), m2);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      check("d0.in_ready", 64'(rdy0), 64'(m0.rdy));
      check("d0.out_valid", 64'(ov0), 64'(m0.hold));
      check("d0.overflow", 64'(of0), 64'(m0.ov));
      if (m0.hold) check("d0.acc_out", 64'(acc0), 64'(m0.res));
      check("d1.in_ready", 64'(rdy1), 64'(m1.rdy));
      check("d1.out_valid", 64'(ov1), 64'(m1.hold));
      check("d1.overflow", 64'(of1), 64'(m1.ov));
      if (m1.hold) check("d1.acc_out", 64'(acc1), 64'(m1.res));
      check("d2.in_ready", 64'(rdy2), 64'(m2.rdy));
      check("d2.out_valid", 64'(ov2), 64'(m2.hold));
      check("d2.overflow", 64'(of2), 64'(m2.ov));
      if (m2.hold) check("d2.acc_out", 64'(acc2), 64'(m2.res));
    end
  end

  // Present n products of value v on group A; returns at #1 after the last accept.
  task automatic run(input int n, input logic [8:0] v);
    int  cnt = 0;
    int  guard = 0;
    bit  a;
    iv = 1'b1; zz = v;
    while (cnt < n && guard < 200) begin
      @(negedge clk);
      a = rdy0;
      @(posedge clk); #1;
      if (a) cnt++;
      guard++;
    end
    iv = 1'b0;
    check("run_accepts", 64'(cnt), 64'(n));
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_ready", 64'(rdy0), 64'd0);
    check("rst.out_valid", 64'(ov0), 64'd0);
    check("rst.acc_out", 64'(acc0), 64'd0);
    check("rst.overflow", 64'(of0), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("rel.in_ready_low", 64'(rdy0), 64'd0);
    @(posedge clk); #1;
    check("rel.in_ready_high", 64'(rdy0), 64'd1);

    // 8 x 465
    ordy = 1'b1;
    run(8, 9'd465);
    check("r1.out_valid", 64'(ov0), 64'd1);
    check("r1.in_ready_low", 64'(rdy0), 64'd0);
    check("r1.acc_out", 64'(acc0), 64'h0E88);
    check("r1.overflow", 64'(of0), 64'd0);
    check("r1w.acc_out", 64'(acc1), SAT ? 64'h7FF : 64'h688);
    check("r1w.overflow", 64'(of1), 64'd1);
    @(posedge clk); #1;
    check("r1.in_ready_back", 64'(rdy0), 64'd1);
    check("r1.out_valid_drop", 64'(ov0), 64'd0);

    // backpressure
    ordy = 1'b0;
    run(8, 9'd1);
    iv = 1'b1; zz = 9'd7;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp.out_valid", 64'(ov0), 64'd1);
      check("bp.acc_out", 64'(acc0), 64'd8);
      check("bp.in_ready", 64'(rdy0), 64'd0);
    end
    ordy = 1'b1;
    run(8, 9'd7);
    check("bp.next_run", 64'(acc0), 64'd56);
    check("bp.sticky_ovf", 64'(of1), 64'd1);
    check("bp.w_next_run", 64'(acc1), 64'd56);

    // clear mid-run
    @(posedge clk); #1;
    run(1, 9'd1); run(1, 9'd2); run(1, 9'd3);
    pulse_clear();
    check("clr.sticky_cleared", 64'(of1), 64'd0);
    run(8, 9'd1);
    check("clr.acc_out", 64'(acc0), 64'd8);

    // clear on the same cycle as the last product
    @(posedge clk); #1;
    run(7, 9'd1);
    iv = 1'b1; zz = 9'd1;
    pulse_clear();
    iv = 1'b0;
    check("clrlast.out_valid", 64'(ov0), 64'd0);
    check("clrlast.in_ready", 64'(rdy0), 64'd1);

    // clear while holding a result
    ordy = 1'b0;
    run(8, 9'd1);
    check("clrhold.pre", 64'(ov0), 64'd1);
    pulse_clear();
    check("clrhold.out_valid", 64'(ov0), 64'd0);
    ordy = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("clrhold.no_result", 64'(ov0), 64'd0);

    // asynchronous reset mid-run
    run(5, 9'd3);
    #3 rst_n = 1'b0;
    #1;
    check("arst.in_ready", 64'(rdy0), 64'd0);
    check("arst.out_valid", 64'(ov0), 64'd0);
    check("arst.acc_out", 64'(acc0), 64'd0);
    check("arst.overflow", 64'(of1), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst.in_ready_rel", 64'(rdy0), 64'd1);
    run(8, 9'd2);
    check("arst.acc_out_run", 64'(acc0), 64'd16);
    @(posedge clk); #1;

    // ACC_COUNT=1 instance
    iv2 = 1'b1; z2 = 9'h1FF;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("c1.in_ready", 64'(rdy2), 64'((k % 2) == 0));
      check("c1.out_valid", 64'(ov2), 64'((k % 2) == 1));
      if ((k % 2) == 1) check("c1.acc_out", 64'(acc2), 64'h1FF);
    end
    @(posedge clk); #1;
    iv2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
